lfsr: RTL and testbench



---
 rtl/lfsr.sv | 39 +++
 tb/tb_lfsr.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lfsr.sv
// lfsr: free-running Fibonacci linear-feedback shift register.
// The state register drives the output directly, so data is glitch-free and has
// no combinational path from any input. A lock-up (all-zero) state reloads the
// seed so the generator can never stall.
module lfsr #(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h8A),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] data
);

    // A zero seed would re-enter lock-up forever, so recovery falls back to 1.
    localparam logic [WIDTH-1:0] RECOVER = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] q;
    logic             fb;

    // Feedback is the parity of the tapped state bits.
    always_comb begin
        fb = ^(q & TAPS);
    end

    // Reset loads the seed; otherwise shift left every edge, escaping lock-up.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else if (q == '0) begin
            q <= RECOVER;
        end else begin
            q <= {q[WIDTH-2:0], fb};
        end
    end

    assign data = q;

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: vector table, hand-written corner sequences and a
// randomized reset run, all checked against a parity-based reference model.
module tb_lfsr;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data8;
    logic [7:0] data0;
    logic [3:0] data4;
    logic [7:0] dataz;

    always #5 clk = ~clk;

    // Default parameters.
    lfsr dut8 (.clk(clk), .reset(reset), .data(data8));

    // No taps: shifts out to zero, exercising lock-up recovery.
    lfsr #(.WIDTH(8), .SEED(8'h8A), .TAPS(8'h00)) dut0 (.clk(clk), .reset(reset), .data(data0));

    // Narrow instance: x^4+x^3+1, period 15.
    lfsr #(.WIDTH(4), .SEED(4'h1), .TAPS(4'hC)) dut4 (.clk(clk), .reset(reset), .data(data4));

    // Zero seed: recovery must fall back to 1.
    lfsr #(.WIDTH(8), .SEED(8'h00), .TAPS(8'hB8)) dutz (.clk(clk), .reset(reset), .data(dataz));

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] m8, m0, m4, mz;

    typedef struct {
        bit         rst;
        logic [7:0] exp;
    } vec_t;

    // Next value from the rules: reset -> seed, zero -> seed (or 1), else shift in parity.
    function automatic logic [7:0] ref_next(logic [7:0] cur, int w, logic [7:0] seed,
                                            logic [7:0] taps, bit rst);
        int mask;
        int par;
        mask = (1 << w) - 1;
        if (rst) return seed;
        if (cur == 8'h00) return (seed == 8'h00) ? 8'h01 : seed;
        par = $countones(cur & taps) % 2;
        return 8'(((int'(cur) << 1) | par) & mask);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock edge with the given reset level; every instance checked against the model.
    task automatic step(bit r);
        reset = r;
        @(posedge clk);
        m8 = ref_next(m8, 8, 8'h8A, 8'hB8, r);
        m0 = ref_next(m0, 8, 8'h8A, 8'h00, r);
        m4 = ref_next(m4, 4, 8'h01, 8'h0C, r);
        mz = ref_next(mz, 8, 8'h00, 8'hB8, r);
        @(negedge clk);
        check("model_default", data8, m8);
        check("model_taps0", data0, m0);
        check("model_width4", {4'h0, data4}, m4);
        check("model_seed0", dataz, mz);
    endtask

    initial begin
        vec_t vecs[7];
        int   seen[256];
        int   first_ret;
        int   bad;
        int   zero_at;
        logic [3:0] seq4[5];

        m8 = 'x; m0 = 'x; m4 = 'x; mz = 'x;
        @(negedge clk);

        // Reset held two edges, then the documented start of the sequence.
        vecs[0] = '{1'b1, 8'h8A};
        vecs[1] = '{1'b1, 8'h8A};
        vecs[2] = '{1'b0, 8'h14};
        vecs[3] = '{1'b0, 8'h29};
        vecs[4] = '{1'b0, 8'h52};
        vecs[5] = '{1'b0, 8'hA5};
        vecs[6] = '{1'b0, 8'h4A};
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].rst);
            check($sformatf("vec%0d", i), data8, vecs[i].exp);
        end

        // Mid-run reset.
        for (int i = 0; i < 20; i++) step(1'b0);
        step(1'b1);
        check("midrun_reset", data8, 8'h8A);
        step(1'b0);
        check("midrun_resume", data8, 8'h14);

        // Period and coverage from the seed.
        step(1'b1);
        check("seed0_reset", dataz, 8'h00);
        foreach (seen[k]) seen[k] = 0;
        first_ret = 0;
        zero_at   = 0;
        for (int i = 1; i <= 255; i++) begin
            step(1'b0);
            seen[data8]++;
            if (data8 == 8'h8A && first_ret == 0) first_ret = i;
            if (data0 == 8'h00 && zero_at == 0) zero_at = i;
            if (i == 1) check("seed0_recover", dataz, 8'h01);
            if (i == 5) seq4[0] = 4'h0;
        end
        check("period_255", first_ret, 255);
        check("zero_never", seen[0], 0);
        bad = 0;
        for (int v = 1; v < 256; v++) if (seen[v] != 1) bad++;
        check("all_nonzero_once", bad, 0);
        // Lowest set bit of 0x8A (bit 1) leaves the register after 7 shifts.
        check("taps0_zero_edge", zero_at, 7);

        // Lock-up recovery, hand sequence.
        step(1'b1);
        for (int i = 0; i < 7; i++) step(1'b0);
        check("lockup_zero", data0, 8'h00);
        step(1'b0);
        check("lockup_reload", data0, 8'h8A);

        // Narrow instance: sequence and period 15.
        step(1'b1);
        check("w4_reset", data4, 4'h1);
        seq4[0] = 4'h2; seq4[1] = 4'h4; seq4[2] = 4'h9; seq4[3] = 4'h3; seq4[4] = 4'h6;
        first_ret = 0;
        for (int i = 1; i <= 15; i++) begin
            step(1'b0);
            if (i <= 5) check($sformatf("w4_seq%0d", i), data4, seq4[i-1]);
            if (data4 == 4'h1 && first_ret == 0) first_ret = i;
        end
        check("w4_period", first_ret, 15);

        // Randomized resets against the model.
        for (int i = 0; i < 2000; i++) step($urandom_range(0, 15) == 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
